pio_read_arbiter: RTL and testbench
===================================

// Module: pio_read_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one Avalon-MM read-only PIO input slave
//  (registered readdata, 1-cycle read latency, 32-bit bus) between NUM_REQ requesters.
//  It sits between the ADC-channel readout logic and the 14-bit PIO sample ports.
//  Each requester raises req with an address and receives one data-valid pulse with
//  the zero-extended sample. Upper-bit corruption is flagged.
// PARAMETERS
//  NUM_REQ       2    number of requesters (2..8)
//  ADDR_W        2    PIO address width
//  DATA_W        14   meaningful readdata bits returned to requesters
//  READ_LATENCY  1    slave read latency in cycles (1..4); wait-state count
// PORTS
//  clk          in   1                clock
//  reset_n      in   1                asynchronous, active-low reset
//  req          in   NUM_REQ          per-requester read request, level; hold until own valid
//  req_addr     in   NUM_REQ*ADDR_W   per-requester address; slice i = [i*ADDR_W +: ADDR_W]
//  rd_valid     out  NUM_REQ          one-cycle pulse to the granted requester: rd_data valid
//  rd_data      out  DATA_W           shared return data = avm_readdata[DATA_W-1:0]
//  avm_address  out  ADDR_W           Avalon master address to PIO slave
//  avm_read     out  1                Avalon read strobe, exactly one cycle per transaction
//  avm_readdata in   32               Avalon read data from PIO slave
//  busy         out  1                high in every state other than IDLE
//  err_upper    out  1                sticky: readdata[31:DATA_W] nonzero on a capture
//  err_clr      in   1                synchronous clear of err_upper
// BEHAVIOUR
//  - Reset (async, any state): FSM->IDLE, rr_ptr=0, all outputs 0, in-flight txn dropped,
//    no rd_valid issued afterwards.
//  - FSM: IDLE -> ISSUE -> WAIT -> CAPTURE -> IDLE. All outputs registered.
//  - IDLE: if |req, pick winner = first set bit scanning from rr_ptr upward, wrapping
//    modulo NUM_REQ. Latch gnt_idx and req_addr[gnt_idx]. Go to ISSUE. Else stay.
//  - ISSUE (1 cycle): avm_read=1, avm_address=latched addr. Next WAIT, lat_cnt=READ_LATENCY-1.
//  - WAIT: decrement lat_cnt. At 0 go to CAPTURE. The slave has presented readdata.
//  - CAPTURE: register rd_data=avm_readdata[DATA_W-1:0]. Pulse rd_valid[gnt_idx]
//    in the next cycle (IDLE). Set err_upper if |avm_readdata[31:DATA_W].
//    Then rr_ptr=(gnt_idx+1)%NUM_REQ.
//  - Latency with READ_LATENCY=1: req seen in IDLE at cycle T -> avm_read at T+1 ->
//    rd_valid at T+4. Throughput: one transaction per 4 cycles.
//  - rd_data holds its last value until the next capture. Only rd_valid qualifies it.
//  - Address is sampled at grant. Changes to req_addr afterwards do not affect the txn.
//  - If req drops mid-transaction, the txn still completes and rd_valid still pulses.
//  - A requester still holding req in the rd_valid cycle is a new request.
//    It wins only if no other requester is pending (rr fairness).
//  - err_clr and a new error in the same cycle: set wins.
//  - avm_address is held 0 whenever avm_read=0.
// STRUCTURE
//  - Shared package pio_arb_pkg: state enum {IDLE,ISSUE,WAIT,CAPTURE},
//    AVM_DATA_W=32, function rr_pick(req, ptr).
//  - One sub-module: rr_arbiter (combinational round-robin pick + index encode,
//    parameter NUM_REQ). The FSM and datapath stay in this module.
// TESTING
//  - Single req[0], addr=0, slave in_port=14'h1ABC -> avm_read 1 cycle at T+1 addr 0;
//    rd_valid=2'b01 at T+4, rd_data=14'h1ABC, err_upper=0.
//  - req=2'b11 held continuously from reset -> grants 0,1,0,1...; rd_valid pulses
//    alternate every 4 cycles. Never two consecutive grants to one requester.
//  - rr_ptr=1, req=2'b01 only -> grant 0 (wrap). Then req=2'b11 -> grant 1.
//  - Slave returns 32'h0001_3FFF -> rd_data=14'h3FFF, err_upper=1 sticky.
//    err_clr pulse -> 0. Set and clr in the same cycle -> remains 1.
//  - reset_n low during WAIT -> all outputs 0 immediately. No rd_valid after release.
//    The next req is served from rr_ptr=0.
//  - READ_LATENCY=3: single req -> avm_read at T+1, rd_valid at T+6, correct data.

Source files
------------

// File: rtl/pio_read_arbiter_pkg.sv
// Shared types and helpers for the PIO read arbiter: FSM state encoding, bus widths
// and the round-robin pick function used by the arbiter sub-module.
package pio_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      CAPTURE = 2'd3
   } state_e;

   localparam int AVM_DATA_W = 32;
   localparam int MAX_REQ    = 8;
   localparam int IDX_W      = 3;

   // First set bit of req scanning upward from ptr, wrapping modulo n.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                input logic [IDX_W-1:0]   ptr,
                                                input int                 n);
      logic [IDX_W-1:0] pick;
      int               j;
      pick = ptr;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         if (k < n) begin
            j = (int'(ptr) + k) % n;
            if (req[j[IDX_W-1:0]]) pick = j[IDX_W-1:0];
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/pio_read_arbiter_if.sv
// Requester-side and Avalon-side signal bundle of the PIO read arbiter.
// The arbiter connects through the slave modport; the environment drives the master side.
interface pio_read_arbiter_if
   import pio_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 2,
   parameter int DATA_W  = 14
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        rd_valid;
   logic [DATA_W-1:0]         rd_data;
   logic [ADDR_W-1:0]         avm_address;
   logic                      avm_read;
   logic [AVM_DATA_W-1:0]     avm_readdata;
   logic                      busy;
   logic                      err_upper;
   logic                      err_clr;

   modport slave (
      input  req, req_addr, avm_readdata, err_clr,
      output rd_valid, rd_data, avm_address, avm_read, busy, err_upper
   );

   modport master (
      output req, req_addr, avm_readdata, err_clr,
      input  rd_valid, rd_data, avm_address, avm_read, busy, err_upper
   );
endinterface

// File: rtl/pio_read_arbiter_rr_arbiter.sv
// Combinational round-robin pick: index of the first pending request at or above ptr.
module rr_arbiter
   import pio_arb_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [IDX_W-1:0]   gnt_idx_o,
   output logic               any_o
);
   logic [MAX_REQ-1:0] req_ext;

   assign req_ext   = MAX_REQ'(req_i);
   assign gnt_idx_o = rr_pick(req_ext, ptr_i, NUM_REQ);
   assign any_o     = |req_i;
endmodule

// File: rtl/pio_read_arbiter.sv
// Round-robin sequencer sharing one Avalon-MM read-only PIO slave between NUM_REQ
// requesters; every output is registered and cleared by the asynchronous reset.
module pio_read_arbiter
   import pio_arb_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int ADDR_W       = 2,
   parameter int DATA_W       = 14,
   parameter int READ_LATENCY = 1
) (
   input logic              clk,
   input logic              reset_n,
   pio_read_arbiter_if.slave bus
);
   state_e               state_q, state_d;
   logic [1:0]           lat_cnt_q, lat_cnt_d;
   logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]     pick_idx;
   logic                 any_req;
   logic [ADDR_W-1:0]    pick_addr;
   logic                 upper_err;

   logic [NUM_REQ-1:0]   rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]    rd_data_q, rd_data_d;
   logic [ADDR_W-1:0]    avm_address_q, avm_address_d;
   logic                 avm_read_q, avm_read_d;
   logic                 busy_q, busy_d;
   logic                 err_upper_q, err_upper_d;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req_i     (bus.req),
      .ptr_i     (rr_ptr_q),
      .gnt_idx_o (pick_idx),
      .any_o     (any_req)
   );

   // The address goes straight into the issue register at grant, so later
   // changes on req_addr cannot reach the transaction.
   assign pick_addr = bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
   assign upper_err = |bus.avm_readdata[AVM_DATA_W-1:DATA_W];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         lat_cnt_q <= '0;
         gnt_idx_q <= '0;
         rr_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
         gnt_idx_q <= gnt_idx_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      gnt_idx_d = gnt_idx_q;
      rr_ptr_d  = rr_ptr_q;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d   = ISSUE;
               gnt_idx_d = pick_idx;
            end
         end
         ISSUE: begin
            state_d   = WAIT;
            lat_cnt_d = 2'(READ_LATENCY - 1);
         end
         WAIT: begin
            if (lat_cnt_q == 2'd0) state_d = CAPTURE;
            else                   lat_cnt_d = lat_cnt_q - 2'd1;
         end
         CAPTURE: begin
            state_d  = IDLE;
            rr_ptr_d = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded one cycle ahead from the next state so they can be registered.
   always_comb begin
      rd_valid_d    = '0;
      rd_data_d     = rd_data_q;
      avm_read_d    = 1'b0;
      avm_address_d = '0;
      busy_d        = (state_d != IDLE);
      err_upper_d   = err_upper_q;
      if (state_q == IDLE && state_d == ISSUE) begin
         avm_read_d    = 1'b1;
         avm_address_d = pick_addr;
      end
      if (state_q == CAPTURE) begin
         rd_valid_d = NUM_REQ'(1) << gnt_idx_q;
         rd_data_d  = bus.avm_readdata[DATA_W-1:0];
      end
      if (bus.err_clr) err_upper_d = 1'b0;
      if (state_q == CAPTURE && upper_err) err_upper_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid_q    <= '0;
         rd_data_q     <= '0;
         avm_address_q <= '0;
         avm_read_q    <= 1'b0;
         busy_q        <= 1'b0;
         err_upper_q   <= 1'b0;
      end else begin
         rd_valid_q    <= rd_valid_d;
         rd_data_q     <= rd_data_d;
         avm_address_q <= avm_address_d;
         avm_read_q    <= avm_read_d;
         busy_q        <= busy_d;
         err_upper_q   <= err_upper_d;
      end
   end

   assign bus.rd_valid    = rd_valid_q;
   assign bus.rd_data     = rd_data_q;
   assign bus.avm_address = avm_address_q;
   assign bus.avm_read    = avm_read_q;
   assign bus.busy        = busy_q;
   assign bus.err_upper   = err_upper_q;
endmodule

// File: tb/tb_pio_read_arbiter.sv
// Bench for pio_read_arbiter: two instances (read latency 1 and 3) share stimulus and
// each has its own PIO slave model; a countdown reference feeds per-instance scoreboards.
module tb_pio_read_arbiter;
   localparam int N  = 2;
   localparam int AW = 2;
   localparam int DW = 14;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [N-1:0]    req;
   logic [N*AW-1:0] req_addr;
   logic            err_clr;
   logic [31:0]     mem [4];

   logic [N-1:0]  rdv [2];
   logic [DW-1:0] rdd [2];
   logic [AW-1:0] aad [2];
   logic          ard [2];
   logic          bsy [2];
   logic          eru [2];

   always #5 clk = ~clk;

   function automatic int rl(input int m);
      return (m == 0) ? 1 : 3;
   endfunction

   for (genvar d = 0; d < 2; d++) begin : g
      localparam int RL = (d == 0) ? 1 : 3;
      pio_read_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
      logic [31:0] pipe [RL];

      pio_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
         .clk     (clk),
         .reset_n (reset_n),
         .bus     (bus)
      );

      assign bus.req          = req;
      assign bus.req_addr     = req_addr;
      assign bus.err_clr      = err_clr;
      assign bus.avm_readdata = pipe[RL-1];

      // Registered PIO slave: data captured on the read strobe, then delayed RL-1 more cycles.
      always @(posedge clk) begin
         if (bus.avm_read) pipe[0] <= mem[bus.avm_address];
         for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
      end

      assign rdv[d] = bus.rd_valid;
      assign rdd[d] = bus.rd_data;
      assign aad[d] = bus.avm_address;
      assign ard[d] = bus.avm_read;
      assign bsy[d] = bus.busy;
      assign eru[d] = bus.err_upper;
   end

   typedef struct {
      int          due;
      logic [N-1:0] vld;
      logic [31:0] data;
   } rsp_t;

   typedef struct {
      int           due;
      logic [AW-1:0] addr;
   } rd_t;

   rsp_t          eq [2][$];
   rd_t           aq [2][$];
   int            cyc;
   int            cnt  [2];
   int            ptr  [2];
   int            gcyc [2];
   int            gidx [2];
   logic [AW-1:0] gaddr [2];
   logic [31:0]   cur  [2];
   logic          errm [2];
   int            nvec = 0;
   int            nmis = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Reference: an instance is free when its countdown is zero; a grant occupies it for
   // ISSUE + RL wait cycles + CAPTURE, and the response shows up in the following cycle.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int m = 0; m < 2; m++) begin
            cnt[m]  = 0;
            ptr[m]  = 0;
            errm[m] = 1'b0;
            eq[m].delete();
            aq[m].delete();
         end
      end else begin
         cyc++;
         for (int m = 0; m < 2; m++) begin
            if (cnt[m] == 1 && (|cur[m][31:DW])) errm[m] = 1'b1;
            else if (err_clr)                     errm[m] = 1'b0;
            if (cnt[m] == 0) begin
               if (req != '0) begin
                  int w;
                  w = 0;
                  for (int k = N - 1; k >= 0; k--)
                     if (req[(ptr[m] + k) % N]) w = (ptr[m] + k) % N;
                  ptr[m]   = (w + 1) % N;
                  gidx[m]  = w;
                  gaddr[m] = req_addr[w*AW +: AW];
                  gcyc[m]  = cyc;
                  cnt[m]   = 2 + rl(m);
                  aq[m].push_back('{due: cyc, addr: gaddr[m]});
               end
            end else begin
               if (cnt[m] == 2 + rl(m)) begin
                  cur[m] = mem[gaddr[m]];
                  eq[m].push_back('{due: gcyc[m] + 2 + rl(m), vld: N'(1) << gidx[m], data: cur[m]});
               end
               cnt[m]--;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int m = 0; m < 2; m++) begin
         chk("busy", 32'(bsy[m]), 32'(cnt[m] != 0));
         chk("err_upper", 32'(eru[m]), 32'(errm[m]));
         if (ard[m]) begin
            if (aq[m].size() == 0) chk("spurious_avm_read", 32'(ard[m]), 32'(0));
            else begin
               rd_t a;
               a = aq[m].pop_front();
               chk("avm_read_cycle", cyc, a.due);
               chk("avm_address", 32'(aad[m]), 32'(a.addr));
            end
         end else begin
            chk("avm_address_idle", 32'(aad[m]), 32'(0));
            if (aq[m].size() != 0 && aq[m][0].due < cyc) begin
               chk("avm_read_missing", 32'(ard[m]), 32'(1));
               void'(aq[m].pop_front());
            end
         end
         if (rdv[m] != '0) begin
            if (eq[m].size() == 0) chk("spurious_rd_valid", 32'(rdv[m]), 32'(0));
            else begin
               rsp_t r;
               r = eq[m].pop_front();
               chk("rd_valid_cycle", cyc, r.due);
               chk("rd_valid", 32'(rdv[m]), 32'(r.vld));
               chk("rd_data", 32'(rdd[m]), 32'(r.data[DW-1:0]));
            end
         end else if (eq[m].size() != 0 && eq[m][0].due < cyc) begin
            chk("rd_valid_missing", 32'(rdv[m]), 32'(eq[m][0].vld));
            void'(eq[m].pop_front());
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input logic [N-1:0] r, input logic [N*AW-1:0] a);
      req      = r;
      req_addr = a;
      step(1);
      req = '0;
   endtask

   initial begin
      reset_n  = 1'b0;
      req      = '0;
      req_addr = '0;
      err_clr  = 1'b0;
      mem[0]   = 32'h0000_1ABC;
      mem[1]   = 32'h0000_2345;
      mem[2]   = 32'h0001_3FFF;
      mem[3]   = 32'h0000_0F0F;
      step(3);
      #2 reset_n = 1'b1;
      step(2);

      // Single requester 0 at address 0.
      pulse(2'b01, {2'd0, 2'd0});
      step(10);

      // Both requesters held through reset release: strict alternation.
      #2 reset_n = 1'b0;
      req      = 2'b11;
      req_addr = {2'd3, 2'd1};
      step(2);
      #2 reset_n = 1'b1;
      step(24);
      req = '0;
      step(10);

      // Pointer wrap, then contention after a grant to 0.
      pulse(2'b01, {2'd1, 2'd3});
      step(10);
      pulse(2'b01, {2'd1, 2'd0});
      step(10);
      pulse(2'b11, {2'd1, 2'd0});
      step(10);

      // Upper-bit corruption: sticky flag, clear, then clear colliding with a new set.
      pulse(2'b01, {2'd0, 2'd2});
      step(10);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      step(3);
      pulse(2'b01, {2'd0, 2'd2});
      step(2);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      step(10);

      // Reset while both instances wait on the slave.
      pulse(2'b10, {2'd1, 2'd0});
      step(1);
      #2 reset_n = 1'b0;
      #1;
      for (int m = 0; m < 2; m++) begin
         chk("rst_rd_valid", 32'(rdv[m]), 32'(0));
         chk("rst_rd_data", 32'(rdd[m]), 32'(0));
         chk("rst_avm_read", 32'(ard[m]), 32'(0));
         chk("rst_avm_address", 32'(aad[m]), 32'(0));
         chk("rst_busy", 32'(bsy[m]), 32'(0));
         chk("rst_err_upper", 32'(eru[m]), 32'(0));
      end
      step(1);
      #2 reset_n = 1'b1;
      step(12);
      pulse(2'b11, {2'd3, 2'd1});
      step(10);

      // Random traffic, addresses, slave contents and clears.
      for (int i = 0; i < 400; i++) begin
         req      = N'($urandom);
         req_addr = (N*AW)'($urandom);
         err_clr  = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 7) == 0)
            mem[$urandom_range(0, 3)] = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_3FFF);
         step(1);
      end
      req     = '0;
      err_clr = 1'b0;
      step(12);

      for (int m = 0; m < 2; m++) begin
         chk("pending_responses", eq[m].size(), 32'(0));
         chk("pending_reads", aq[m].size(), 32'(0));
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
